ga_lsu_responder: RTL
=====================

Name: ga_lsu_responder

Overview:
- Memory-mapped responder for the Ibex core's LSU data bus (req/gnt/rvalid). It is the target end of the core's data interface.
- Backs a word-addressed scratch register array used as GA coprocessor operand/result storage.
- Fixed-latency, in-order responses with bounded outstanding transactions.
- Flags out-of-range accesses with a bus error.

Parameters:
- BaseAddr, 32'h0002_0000, byte base address of the window; must be NumWords*4 aligned.
- NumWords, 64, number of 32-bit words in the array; power of two, 2..1024.
- Latency, 1, cycles from grant to rvalid; legal range 1..4.
- MaxOutstanding, 2, maximum granted-but-unanswered transactions; legal range 1..4.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-high reset.
- data_req_i  in  1  request valid from core.
- data_gnt_o  out  1  request accepted this cycle.
- data_we_i  in  1  1 = write, 0 = read.
- data_be_i  in  4  byte enables.
- data_addr_i  in  32  byte address; bits [1:0] ignored.
- data_wdata_i  in  32  write data.
- data_rvalid_o  out  1  response valid, one cycle per granted request.
- data_rdata_o  out  32  read data; 0 when rvalid low, for writes, or on error.
- data_err_o  out  1  error qualifier, meaningful only with rvalid.
- busy_o  out  1  high while outstanding count is nonzero.

Behaviour:
- Reset, asynchronous: gnt 0, rvalid 0, rdata 0, err 0, busy 0. Outstanding count 0, latency pipeline cleared, all array words 0.
- Reset asserted mid-transaction drops in-flight responses. No rvalid is produced for them after reset deasserts.

Grant:
- data_gnt_o = data_req_i & ~rst_i & (cnt < MaxOutstanding), combinational.
- cnt is the pre-edge count; a response retiring in the same cycle does not free a slot until the next cycle.
- The core may hold req with stable fields while gnt is low. No request is lost or duplicated.

Address decode:
- off = data_addr_i - BaseAddr, 32-bit unsigned.
- In range iff off < NumWords*4.
- Word index = off[log2(NumWords)+1:2].

Grant-cycle actions:
- Write, in range: each byte lane whose be bit is set is updated at the grant edge. be = 0 is a no-op that still gets a response.
- Read, in range: the word is sampled at the grant edge, so a write granted the previous cycle is visible. Captured data travels down the latency pipeline.
- Out of range, read or write: no array change. Response carries err = 1 and rdata = 0.

Response:
- rvalid asserts exactly Latency cycles after the grant edge, i.e. grant in cycle N gives rvalid in cycle N+Latency.
- Responses are in grant order and never merged.
- Back-to-back grants give back-to-back rvalids.

Counter:
- +1 on grant, -1 on rvalid; both in one cycle leaves it unchanged.
- cnt never exceeds MaxOutstanding and never underflows.
- With MaxOutstanding < Latency, throughput is MaxOutstanding per Latency+1 cycles.
- busy_o = (cnt != 0), registered along with cnt.

Optional Feature:
- Macro GA_LSU_RESP_STALL_EN.
- Defined: an internal 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), reset to 8'hA5, advances every cycle. When its bit 0 is 1, data_gnt_o is additionally forced low. This stresses the core's gnt-wait path; latency after grant is unchanged.
- Undefined: no LFSR logic, and grant follows the rule above only.

Test Plan:
- Reset then single write 32'hDEADBEEF, be 4'hF, to 0x0002_0010, then read same address. Response: write rvalid at grant+1 with err 0 and rdata 0; read rvalid returns 32'hDEADBEEF.
- Byte-lane write: word 3 preset 32'h1122_3344, then write 32'hAABB_CCDD with be 4'b0101. Read returns 32'h11BB_33DD. A be = 0 write leaves it unchanged and still acks.
- Out-of-range: read 0x0002_0100 with NumWords 64, and write 0x0001_FFFC. Each gets rvalid with err = 1, rdata 0; array contents unchanged on readback.
- Outstanding limit: Latency 4, MaxOutstanding 2, req held high for 8 cycles. gnt high cycles 0,1, low cycles 2..4, high again at cycle 5. rvalid at cycles 4,5; cnt never exceeds 2.
- Read-after-write pipelining: Latency 1, back-to-back write 32'h5 then read to word 7. Read returns 32'h5 in the cycle after the write's rvalid.
- Reset mid-flight: Latency 3, grant a read, assert rst_i 1 cycle later for 1 cycle. No rvalid ever appears for that read, and busy_o = 0 after reset.

Source files
------------

// File: rtl/ga_lsu_responder.sv
// Ibex LSU data-bus responder backing a word-addressed scratch array with fixed-latency, in-order responses.
// Optional grant stalling from an internal LFSR is enabled by defining GA_LSU_RESP_STALL_EN.
module ga_lsu_responder #(
  parameter logic [31:0] BaseAddr       = 32'h0002_0000,
  parameter int unsigned NumWords       = 64,
  parameter int unsigned Latency        = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        busy_o
);

  localparam int unsigned IdxW = $clog2(NumWords);
  localparam int unsigned CntW = 3;
  localparam logic [31:0] WinBytes = 32'(NumWords * 4);

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } resp_t;

  localparam int unsigned PipeW = Latency * $bits(resp_t);

  logic [31:0]           mem_q [NumWords];
  resp_t [Latency-1:0]   pipe_q;
  resp_t                 stage0;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  busy_q;
  logic [31:0]           off;
  logic                  in_range;
  logic [IdxW-1:0]       idx;
  logic                  stall;
  logic                  rvalid;

  assign off      = data_addr_i - BaseAddr;
  assign in_range = off < WinBytes;
  assign idx      = off[IdxW+1:2];

`ifdef GA_LSU_RESP_STALL_EN
  logic [7:0] lfsr_q;

  // Fibonacci LFSR, taps for x^8+x^6+x^5+x^4+1
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  // Slot accounting uses the pre-edge count; a retiring response frees its slot next cycle
  assign data_gnt_o = data_req_i & ~rst_i & ~stall & (cnt_q < CntW'(MaxOutstanding));

  assign rvalid        = pipe_q[Latency-1].valid;
  assign data_rvalid_o = rvalid;
  assign data_err_o    = rvalid & pipe_q[Latency-1].err;
  assign data_rdata_o  = rvalid ? pipe_q[Latency-1].data : '0;
  assign busy_o        = busy_q;

  always_comb begin
    stage0 = '0;
    if (data_gnt_o) begin
      stage0.valid = 1'b1;
      if (!in_range) begin
        stage0.err = 1'b1;
      end else if (!data_we_i) begin
        stage0.data = mem_q[idx];
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (data_gnt_o && !rvalid) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!data_gnt_o && rvalid) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Shift by concatenation and truncation so a single-stage pipeline needs no special case
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      pipe_q <= PipeW'({pipe_q, stage0});
      cnt_q  <= cnt_d;
      busy_q <= (cnt_d != '0);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned w = 0; w < NumWords; w++) begin
        mem_q[w] <= '0;
      end
    end else if (data_gnt_o && data_we_i && in_range) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (data_be_i[b]) begin
          mem_q[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
        end
      end
    end
  end

endmodule
